demux_1x8: RTL
==============

# demux_1x8

Registered 1-to-8 demultiplexer with a valid/ready handshake: steers one `width`-bit input word into one of eight single-entry output holding registers chosen by a 3-bit select, or into all eight at once (broadcast). It is the write-side counterpart of the 8:1 bus multiplexer. It distributes a shared source bus to eight consumers, each of which releases its slot with a per-channel acknowledge. Each channel buffers one word, giving backpressure per destination.

## Interface
Parameters:
- `width`, 8, data word width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  block enable; gates acceptance and output drive
- `in_data`  in  width  word to deliver
- `select`  in  3  destination channel 0..7
- `bcast`  in  1  1 = deliver `in_data` to all eight channels; `select` ignored
- `in_valid`  in  1  source presents a word
- `in_ready`  out  1  block can accept this cycle (combinational)
- `o0`..`o7`  out  width  channel data; `{width{1'bz}}` when not driven
- `out_valid`  out  8  bit k = channel k holds an unconsumed word
- `out_ack`  in  8  bit k = consumer k takes its word this cycle
- `xfer_cnt`  out  8  accepted-transfer count, wraps 255→0

## Operation
- Per-channel state: data register `d[k]`, flag `out_valid[k]`.
- `in_ready` = `en` & (`bcast` ? all `out_valid` bits clear : ~`out_valid[select]`). It uses registered flags only, so it does not depend on `out_ack`.
- Accept = `in_valid` & `in_ready`:
  - Unicast: `d[select]` ← `in_data` and `out_valid[select]` ← 1.
  - Broadcast: every `d[k]` ← `in_data` and every `out_valid[k]` ← 1.
  - On any accept, `xfer_cnt` += 1. Broadcast counts as one transfer.
- Ack: `out_ack[k]` & `out_valid[k]` clears `out_valid[k]` at the next edge. `d[k]` holds its value.
  - An ack on an empty channel is ignored.
  - Acks are processed even when `en`=0.
- Ack and accept on the same channel in the same cycle cannot both happen, because that channel is not ready. There is no fall-through: a freed channel accepts one cycle after its ack at the earliest.
- Accept on channel j and ack on channel k≠j in the same cycle: both take effect.
- `in_valid` with `in_ready`=0: the word is not taken and no state changes. The source must hold it.
- Output drive: `o_k` = (`en` & `out_valid[k]`) ? `d[k]` : `{width{1'bz}}`.
- `en`=0: `in_ready`=0 and all `o_k` are z. Flags and data are retained, and re-asserting `en` restores the drive.

## Timing
- Reset (`rst`=1 at an edge): all `d[k]`=0, `out_valid`=8'h00, `xfer_cnt`=0.
  - `in_ready` then follows `en`, since all channels are empty.
  - All `o_k` are z.
- Reset has priority over a same-cycle accept or ack. A word offered in the reset cycle is dropped and not counted.
- Latency: an accept at edge N makes `out_valid[k]`=1 and `o_k` valid from just after edge N to the edge of its ack.
- Throughput:
  - Unicast: one word per cycle when successive words target empty channels.
  - A single channel: one word per two cycles (accept, ack, accept).
- `in_ready` and `o_k` are combinational from registers and inputs. There is no combinational path from `out_ack` to `in_ready`.
- `xfer_cnt` wraps at 256 accepts with no flag.

## Test plan
- **Reset:** assert `rst` 2 cycles with `in_valid`=1 → `out_valid`=8'h00, `xfer_cnt`=0, all `o_k`=z, `in_ready`=1 after release (`en`=1).
- **Unicast sweep:** `en`=1; send 8'hA0+k to `select`=k for k=0..7 on consecutive cycles; no acks → each accepted one cycle apart, `out_valid`=8'hFF, `o3`=8'hA3, `xfer_cnt`=8. A ninth word to `select`=5 gives `in_ready`=0.
- **Backpressure/ack:** channel 2 full; pulse `out_ack`=8'h04 while offering 8'h55 to channel 2 → not accepted in the ack cycle, accepted the next cycle, `o2`=8'h55.
- **Broadcast:** all channels empty, `bcast`=1, 8'h3C → all `o_k`=8'h3C, `out_valid`=8'hFF, `xfer_cnt` +1. With channel 6 full, `bcast` gives `in_ready`=0.
- **Enable gating:** channels 0,1 full; drop `en` → `o0`,`o1`=z, `in_ready`=0. `out_ack`=8'h01 still clears bit 0. Re-enable → `o1` driven with its old value, `o0`=z.
- **Wrap:** 256 accepted transfers → `xfer_cnt`=0; concurrent accept on channel 1 plus ack on channel 4 → both take effect in one edge.

Source files
------------

// File: rtl/demux_1x8.sv
// demux_1x8: registered 1-to-8 demultiplexer; steers one word into a single
// channel holding register (select) or into all eight (bcast), with a
// per-channel ack releasing each slot.
// Latency: accepted word is visible on o<k>/out_valid[k] right after the accepting edge.
// Backpressure: in_ready drops when the target channel (or, for broadcast, any channel) is full or en=0.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   en                  - block enable; gates acceptance and output drive
//   in_data/select/bcast/in_valid/in_ready - source side handshake
//   o0..o7, out_valid   - per-channel data (z when not driven) and full flags
//   out_ack             - per-channel consume strobe
//   xfer_cnt            - accepted transfer count, wraps at 256
module demux_1x8 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] in_data,
    input  logic [2:0]       select,
    input  logic             bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] o0,
    output logic [width-1:0] o1,
    output logic [width-1:0] o2,
    output logic [width-1:0] o3,
    output logic [width-1:0] o4,
    output logic [width-1:0] o5,
    output logic [width-1:0] o6,
    output logic [width-1:0] o7,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ack,
    output logic [7:0]       xfer_cnt
);

    logic [width-1:0] data_q [8];
    logic [width-1:0] data_d [8];
    logic [7:0]       valid_q;
    logic [7:0]       valid_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic             accept;
    logic [7:0]       drive;

    // Ready looks only at registered flags, so out_ack never reaches in_ready
    // combinationally; a freed slot becomes acceptable one cycle after its ack.
    always_comb begin
        in_ready = en & (bcast ? (valid_q == 8'h00) : ~valid_q[select]);
        accept   = in_valid & in_ready;

        // Ack on an empty channel is a no-op because the flag is already 0.
        valid_d = valid_q & ~out_ack;
        for (int k = 0; k < 8; k++) begin
            data_d[k] = data_q[k];
        end
        cnt_d = cnt_q;

        if (accept) begin
            if (bcast) begin
                valid_d = 8'hFF;
                for (int k = 0; k < 8; k++) begin
                    data_d[k] = in_data;
                end
            end else begin
                valid_d[select] = 1'b1;
                data_d[select]  = in_data;
            end
            // Broadcast counts as a single transfer.
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 8'h00;
            cnt_q   <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Channels release the shared bus when disabled or empty; contents are kept.
    assign drive = {8{en}} & valid_q;

    assign o0 = drive[0] ? data_q[0] : {width{1'bz}};
    assign o1 = drive[1] ? data_q[1] : {width{1'bz}};
    assign o2 = drive[2] ? data_q[2] : {width{1'bz}};
    assign o3 = drive[3] ? data_q[3] : {width{1'bz}};
    assign o4 = drive[4] ? data_q[4] : {width{1'bz}};
    assign o5 = drive[5] ? data_q[5] : {width{1'bz}};
    assign o6 = drive[6] ? data_q[6] : {width{1'bz}};
    assign o7 = drive[7] ? data_q[7] : {width{1'bz}};

    assign out_valid = valid_q;
    assign xfer_cnt  = cnt_q;

endmodule
